// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, their response strobes and the shared ALU port
// that sit between alu_arbiter and its environment.
interface alu_arbiter_if #(
    parameter int NUM_SIZE      = 32,
    parameter int CMD_SIZE_LOG2 = 2
);
    localparam int CW = 2 ** CMD_SIZE_LOG2;

    logic                       req0_valid, req1_valid;
    logic                       req0_ready, req1_ready;
    logic signed [NUM_SIZE-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic        [CW-1:0]       req0_cmd, req1_cmd;

    logic                       rsp0_valid, rsp1_valid;
    logic signed [NUM_SIZE-1:0] rsp0_data, rsp1_data;
    logic                       rsp0_err, rsp1_err;

    logic                       alu_enable, alu_reset;
    logic signed [NUM_SIZE-1:0] alu_in1, alu_in2;
    logic        [CW-1:0]       alu_cmd;
    logic signed [NUM_SIZE-1:0] alu_out;

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_cmd,
        output req1_valid, req1_in1, req1_in2, req1_cmd,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_err,
        input  rsp1_valid, rsp1_data, rsp1_err,
        input  alu_enable, alu_reset, alu_in1, alu_in2, alu_cmd,
        output alu_out
    );

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_cmd,
        input  req1_valid, req1_in1, req1_in2, req1_cmd,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_err,
        output rsp1_valid, rsp1_data, rsp1_err,
        output alu_enable, alu_reset, alu_in1, alu_in2, alu_cmd,
        input  alu_out
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters; only ADD and
// NOOP are legal, anything else is answered with an error response.
module alu_arbiter #(
    parameter int NUM_SIZE      = 32,
    parameter int CMD_SIZE_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    alu_arbiter_if.slave bus,
    output logic [15:0] issue_count,
    output logic        err_sticky
);
    localparam int CW = 2 ** CMD_SIZE_LOG2;
    localparam logic [CW-1:0] CMD_NOOP = '0;
    localparam logic [CW-1:0] CMD_ADD  = CW'(1);

    typedef enum logic [1:0] {
        RSP_ZERO,
        RSP_ADD,
        RSP_ERR
    } rsp_kind_t;

    logic                       prio1;
    logic                       grant0, grant1, accept;
    logic        [CW-1:0]       sel_cmd;
    logic signed [NUM_SIZE-1:0] sel_in1, sel_in2;
    logic                       cmd_add, cmd_legal;

    logic                       pend_valid;
    logic                       pend_owner;
    rsp_kind_t                  pend_kind;
    logic                       rsp_live;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && (!bus.req1_valid || !prio1))
                grant0 = 1'b1;
            else if (bus.req1_valid)
                grant1 = 1'b1;
        end
    end

    assign accept         = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        sel_cmd   = grant1 ? bus.req1_cmd : bus.req0_cmd;
        sel_in1   = grant1 ? bus.req1_in1 : bus.req0_in1;
        sel_in2   = grant1 ? bus.req1_in2 : bus.req0_in2;
        cmd_add   = (sel_cmd == CMD_ADD);
        cmd_legal = cmd_add || (sel_cmd == CMD_NOOP);
    end

    // Only an accepted ADD reaches the ALU; everything else presents NOOP with zero operands.
    always_comb begin
        bus.alu_enable = 1'b1;
        bus.alu_reset  = reset;
        bus.alu_cmd    = CMD_NOOP;
        bus.alu_in1    = '0;
        bus.alu_in2    = '0;
        if (accept && cmd_add) begin
            bus.alu_cmd = CMD_ADD;
            bus.alu_in1 = sel_in1;
            bus.alu_in2 = sel_in2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_owner  <= 1'b0;
            pend_kind   <= RSP_ZERO;
            prio1       <= 1'b0;
            issue_count <= '0;
            err_sticky  <= 1'b0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_owner  <= grant1;
                pend_kind   <= cmd_add ? RSP_ADD : (cmd_legal ? RSP_ZERO : RSP_ERR);
                prio1       <= grant0;
                issue_count <= issue_count + 16'd1;
                if (!cmd_legal)
                    err_sticky <= 1'b1;
            end
        end
    end

    // Gating with reset suppresses a response that was in flight when reset rose.
    assign rsp_live = pend_valid && !reset;

    always_comb begin
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp0_data  = '0;
        bus.rsp1_data  = '0;
        bus.rsp0_err   = 1'b0;
        bus.rsp1_err   = 1'b0;
        if (rsp_live) begin
            if (pend_owner) begin
                bus.rsp1_valid = 1'b1;
                bus.rsp1_err   = (pend_kind == RSP_ERR);
                if (pend_kind == RSP_ADD)
                    bus.rsp1_data = bus.alu_out;
            end else begin
                bus.rsp0_valid = 1'b1;
                bus.rsp0_err   = (pend_kind == RSP_ERR);
                if (pend_kind == RSP_ADD)
                    bus.rsp0_data = bus.alu_out;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with a behavioural ALU and a
// transaction-level reference model of arbitration and responses.
module tb_alu_arbiter;
    localparam int N = 32;
    localparam logic [3:0] NOOP = 4'd0;
    localparam logic [3:0] ADD  = 4'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] issue_count;
    logic        err_sticky;

    alu_arbiter_if #(.NUM_SIZE(N), .CMD_SIZE_LOG2(2)) bus ();

    alu_arbiter #(.NUM_SIZE(N), .CMD_SIZE_LOG2(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .issue_count (issue_count),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU: registered sum, one cycle latency.
    always @(posedge clk)
        bus.alu_out <= (bus.alu_cmd == ADD) ? bus.alu_in1 + bus.alu_in2 : '0;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    int          last_grant;
    int unsigned mcount;
    bit          msticky;

    // Per-cycle expectations handed from stimulus to monitor
    bit          armed = 1'b0;
    bit          e_r0, e_r1, e_reset;
    logic [3:0]  e_cmd;
    logic [31:0] e_in1, e_in2;
    logic [15:0] e_count;
    bit          e_sticky;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit v0, input bit v1,
                         input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
        int   g;
        rsp_t r;
        logic [3:0]  c;
        logic [31:0] a, b;
        @(posedge clk);
        #1;
        reset = rst;
        bus.req0_valid = v0; bus.req0_cmd = c0; bus.req0_in1 = a0; bus.req0_in2 = b0;
        bus.req1_valid = v1; bus.req1_cmd = c1; bus.req1_in1 = a1; bus.req1_in2 = b1;

        e_count  = mcount[15:0];
        e_sticky = msticky;
        e_reset  = rst;
        e_r0 = 1'b0; e_r1 = 1'b0;
        e_cmd = NOOP; e_in1 = '0; e_in2 = '0;

        if (rst) begin
            exp_q.delete();
            last_grant = 1;
            mcount = 0;
            msticky = 1'b0;
        end else begin
            g = -1;
            if (v0 && v1) g = (last_grant == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
            if (g >= 0) begin
                last_grant = g;
                mcount++;
                c = (g == 0) ? c0 : c1;
                a = (g == 0) ? a0 : a1;
                b = (g == 0) ? b0 : b1;
                if (g == 0) e_r0 = 1'b1; else e_r1 = 1'b1;
                r.owner = g;
                r.due   = cyc + 1;
                if (c == ADD) begin
                    r.data = a + b;
                    r.err  = 1'b0;
                    e_cmd = ADD; e_in1 = a; e_in2 = b;
                end else if (c == NOOP) begin
                    r.data = '0;
                    r.err  = 1'b0;
                end else begin
                    r.data = '0;
                    r.err  = 1'b1;
                    msticky = 1'b1;
                end
                exp_q.push_back(r);
            end
        end
        armed = 1'b1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, NOOP, '0, '0, NOOP, '0, '0);
    endtask

    // Monitor: compares combinational outputs and drains the response scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            rsp_t e;
            chk("req0_ready", bus.req0_ready, e_r0);
            chk("req1_ready", bus.req1_ready, e_r1);
            chk("alu_cmd", bus.alu_cmd, e_cmd);
            chk("alu_in1", $unsigned(bus.alu_in1), e_in1);
            chk("alu_in2", $unsigned(bus.alu_in2), e_in2);
            chk("alu_enable", bus.alu_enable, 1'b1);
            chk("alu_reset", bus.alu_reset, e_reset);
            chk("issue_count", issue_count, e_count);
            chk("err_sticky", err_sticky, e_sticky);
            chk("rsp_both", bus.rsp0_valid && bus.rsp1_valid, 1'b0);
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected cycle=%0d actual=rsp0:%0b rsp1:%0b expected=none",
                             cyc, bus.rsp0_valid, bus.rsp1_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_owner", bus.rsp1_valid ? 1 : 0, e.owner);
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_data", bus.rsp1_valid ? $unsigned(bus.rsp1_data) : $unsigned(bus.rsp0_data), e.data);
                    chk("rsp_err", bus.rsp1_valid ? bus.rsp1_err : bus.rsp0_err, e.err);
                end
            end else begin
                chk("rsp_idle_data", $unsigned(bus.rsp0_data) | $unsigned(bus.rsp1_data), 32'd0);
                chk("rsp_idle_err", bus.rsp0_err | bus.rsp1_err, 1'b0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL rsp_missing cycle=%0d actual=none expected=owner%0d data=%0h",
                             cyc, e.owner, e.data);
                end
            end
        end
    end

    initial begin
        logic [3:0] rc [2];
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_cmd = NOOP; bus.req1_cmd = NOOP;
        bus.req0_in1 = '0; bus.req0_in2 = '0; bus.req1_in1 = '0; bus.req1_in2 = '0;
        last_grant = 1; mcount = 0; msticky = 1'b0;
        repeat (2) @(posedge clk);
        drive(1'b1, 1'b1, 1'b1, ADD, 32'd1, 32'd2, ADD, 32'd3, 32'd4);

        // Single requester ADD 5+7
        drive(1'b0, 1'b1, 1'b0, ADD, 32'd5, 32'd7, NOOP, '0, '0);
        idle();
        @(negedge clk);
        chk("add_count", issue_count, 16'd1);

        // Contention straight after reset: grants 0,1,0,1
        drive(1'b1, 1'b0, 1'b0, NOOP, '0, '0, NOOP, '0, '0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 1'b1, ADD, $urandom, $urandom, ADD, $urandom, $urandom);
        idle();

        // Signed overflow passes through unmodified
        drive(1'b0, 1'b0, 1'b1, NOOP, '0, '0, ADD, 32'h7FFF_FFFF, 32'd1);
        idle();

        // Illegal command, sticky error persists
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'd9, 32'd9, NOOP, '0, '0);
        idle();
        idle();
        @(negedge clk);
        chk("sticky_hold", err_sticky, 1'b1);

        // Reset right after an accepted ADD discards the response
        drive(1'b0, 1'b1, 1'b0, ADD, 32'd10, 32'd20, NOOP, '0, '0);
        drive(1'b1, 1'b0, 1'b0, NOOP, '0, '0, NOOP, '0, '0);
        idle();
        idle();

        // Randomised traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 7))
                    0, 1, 2, 3: rc[k] = ADD;
                    4, 5:       rc[k] = NOOP;
                    default:    rc[k] = 4'($urandom_range(2, 15));
                endcase
            end
            drive($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rc[0], $urandom, $urandom, rc[1], $urandom, $urandom);
        end
        idle();

        // issue_count wraps after 65536 accepts
        drive(1'b1, 1'b0, 1'b0, NOOP, '0, '0, NOOP, '0, '0);
        for (int i = 0; i < 65536; i++)
            drive(1'b0, 1'b1, 1'b0, NOOP, '0, '0, NOOP, '0, '0);
        idle();
        @(negedge clk);
        chk("count_wrap", issue_count, 16'd0);
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_SIZE, default 32, operand/result width in bits.
REQ-002 Parameter CMD_SIZE_LOG2, default 2; command width CW = 2**CMD_SIZE_LOG2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  operation from requester N accepted this cycle.
REQ-007 reqN_in1, reqN_in2  input  NUM_SIZE signed  operands from requester N.
REQ-008 reqN_cmd  input  CW  command from requester N.
REQ-009 rspN_valid  output  1  one-cycle result strobe to requester N.
REQ-010 rspN_data  output  NUM_SIZE signed  result to requester N.
REQ-011 rspN_err  output  1  the operation was rejected as an illegal command.
REQ-012 alu_enable, alu_reset  output  1  enable/reset to the shared ALU.
REQ-013 alu_in1, alu_in2  output  NUM_SIZE signed; alu_cmd  output  CW  ALU operation.
REQ-014 alu_out  input  NUM_SIZE signed  ALU registered result (1-cycle latency, no valid used).
REQ-015 issue_count  output  16  total accepted operations, wraps at 2^16.
REQ-016 err_sticky  output  1  set on any illegal command, cleared only by reset.

Function
REQ-017 At most one operation accepted per cycle; handshake = reqN_valid && reqN_ready.
REQ-018 reqN_ready is combinational; it is never high without reqN_valid, and never high for both requesters in the same cycle.
REQ-019 Round-robin: single valid requester is granted; when both are valid, the requester not granted last is granted; priority pointer moves only on an accepted handshake.
REQ-020 Legal commands: NOOP and ADD (codes from the shared definitions header); all other codes are illegal.
REQ-021 Accepted ADD: in the same cycle alu_in1/alu_in2/alu_cmd = granted requester's fields; the next cycle rspN_valid=1, rspN_data=alu_out, rspN_err=0.
REQ-022 Accepted NOOP: alu_cmd=NOOP; the next cycle rspN_valid=1, rspN_data=0, rspN_err=0.
REQ-023 Accepted illegal command: alu_cmd=NOOP (never forwarded); the next cycle rspN_valid=1, rspN_data=0, rspN_err=1; err_sticky is set.
REQ-024 Idle cycle (no handshake): alu_cmd=NOOP, alu_in1=alu_in2=0.
REQ-025 One-deep response pipeline (owner tag + kind); back-to-back acceptance every cycle, full throughput, no bubbles.
REQ-026 Exactly one rspN_valid pulse per accepted operation; rsp0_valid and rsp1_valid are never high together; rsp outputs are 0 when rspN_valid=0.
REQ-027 The arbiter does no arithmetic; the ADD result wraps modulo 2^NUM_SIZE inside the ALU and is passed through unmodified.
REQ-028 alu_enable=1 at all times; alu_reset = reset (combinational).
REQ-029 issue_count increments by 1 per accepted operation (legal or illegal) and wraps 0xFFFF->0x0000.

Reset
REQ-030 While reset=1: reqN_ready=0, rspN_valid=0, rspN_data=0, rspN_err=0, alu_cmd=NOOP, alu operands 0.
REQ-031 On the first cycle after reset: issue_count=0, err_sticky=0, pointer favours requester 0.
REQ-032 Reset mid-operation: an in-flight response is discarded; no rspN_valid in the cycle after reset deasserts.

Verification
REQ-033 Req0 only, ADD 5+7 -> req0_ready same cycle; next cycle rsp0_valid=1, rsp0_data=12, rsp0_err=0; issue_count=1.
REQ-034 Both valid continuously for 4 cycles after reset -> grants 0,1,0,1; responses alternate rsp0/rsp1, one per cycle.
REQ-035 Req1 ADD 0x7FFFFFFF+1 (NUM_SIZE=32) -> rsp1_data=0x80000000.
REQ-036 Req0 cmd illegal (e.g. 0xF) -> alu_cmd=NOOP; next cycle rsp0_err=1, rsp0_data=0; err_sticky=1 until reset.
REQ-037 Accept ADD, assert reset the following cycle -> no rsp0_valid/rsp1_valid; all outputs at reset values.
REQ-038 65536 accepted operations from reset -> issue_count returns to 0.
